// File: rtl/pgm_wrx.sv
// Packet write front-end: bypasses ordinary packets downstream, or stores STORE_TYPE packets
// into RAM and then holds off upstream for cfg_interval cycles. Define PGM_WRX_STATS_EN for stats.
module pgm_wrx #(
    parameter int unsigned DATA_W     = 134,
    parameter int unsigned PHV_W      = 1024,
    parameter int unsigned RAM_AW     = 7,
    parameter int unsigned RAM_DW     = 144,
    parameter logic [2:0]  STORE_TYPE = 3'b111
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [DATA_W-1:0]   in_wr_data,
    input  logic                in_wr_data_wr,
    input  logic [PHV_W-1:0]    in_wr_phv,
    input  logic                in_wr_phv_wr,
    input  logic                in_wr_valid,
    input  logic                in_wr_valid_wr,
    output logic [DATA_W-1:0]   out_wr_data,
    output logic                out_wr_data_wr,
    output logic [PHV_W-1:0]    out_wr_phv,
    output logic                out_wr_phv_wr,
    output logic                out_wr_valid,
    output logic                out_wr_valid_wr,
    input  logic                in_wr_alf,
    input  logic                in_wr_phv_alf,
    output logic                out_wr_alf,
    output logic                out_wr_phv_alf,
    output logic                wr2ram_wr_en,
    output logic [RAM_AW-1:0]   wr2ram_addr,
    output logic [RAM_DW-1:0]   wr2ram_wdata,
    input  logic [31:0]         cfg_interval,
    output logic                pgm_bypass_flag,
    output logic                pgm_sent_start_flag,
    output logic                pgm_sent_finish_flag,
    output logic [RAM_AW:0]     pgm_pkt_len,
    output logic                pgm_store_err,
    output logic [31:0]         stat_bypass_cnt,
    output logic [31:0]         stat_store_cnt,
    output logic [31:0]         stat_drop_cnt
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] BYPASS  = 3'd1;
    localparam logic [2:0] STORE   = 3'd2;
    localparam logic [2:0] WAIT    = 3'd3;
    localparam logic [2:0] DISCARD = 3'd4;

    localparam logic [RAM_AW-1:0] ADDR_MAX = '1;
    localparam logic [RAM_AW-1:0] ADDR_ONE = 1;
    localparam logic [RAM_AW:0]   LEN_OFS  = 2;

    logic [2:0]        state_q, state_d;
    logic [31:0]       wait_cnt_q;
    logic [1:0]        tag;
    logic              is_head, is_mid, is_tail;
    logic              fwd, fwd_head, fwd_tail, trunc;
    logic              ram_wr, store_done, store_err, finish, ev_drop;
    logic [RAM_AW-1:0] wr_addr;

    assign tag     = in_wr_data[DATA_W-1 -: 2];
    assign is_head = in_wr_data_wr && (tag == 2'b01);
    assign is_mid  = in_wr_data_wr && (tag == 2'b11);
    assign is_tail = in_wr_data_wr && (tag == 2'b10);

    assign out_wr_alf     = in_wr_alf     | (state_q == WAIT);
    assign out_wr_phv_alf = in_wr_phv_alf | (state_q == WAIT);

    always_comb begin
        state_d    = state_q;
        fwd        = 1'b0;
        fwd_head   = 1'b0;
        fwd_tail   = 1'b0;
        trunc      = 1'b0;
        ram_wr     = 1'b0;
        wr_addr    = wr2ram_addr + ADDR_ONE;
        store_done = 1'b0;
        store_err  = 1'b0;
        finish     = 1'b0;
        ev_drop    = 1'b0;
        case (state_q)
            IDLE: begin
                if (is_head) begin
                    if (in_wr_data[111:109] == STORE_TYPE) begin
                        ram_wr  = 1'b1;
                        wr_addr = '0;
                        state_d = STORE;
                    end else begin
                        fwd      = 1'b1;
                        fwd_head = 1'b1;
                        state_d  = BYPASS;
                    end
                end
            end
            BYPASS: begin
                if (is_head) begin
                    trunc   = 1'b1;
                    ev_drop = 1'b1;
                    state_d = DISCARD;
                end else if (is_tail) begin
                    fwd      = 1'b1;
                    fwd_tail = 1'b1;
                    state_d  = IDLE;
                end else if (is_mid) begin
                    fwd = 1'b1;
                end
            end
            STORE: begin
                if (is_head) begin
                    store_err = 1'b1;
                    state_d   = DISCARD;
                end else if (is_mid || is_tail) begin
                    // RAM full: a tail here would be one word too many, so it ends the packet as an error
                    if (wr2ram_addr == ADDR_MAX) begin
                        store_err = 1'b1;
                        state_d   = is_tail ? IDLE : DISCARD;
                    end else begin
                        ram_wr = 1'b1;
                        if (is_tail) begin
                            store_done = 1'b1;
                            state_d    = WAIT;
                        end
                    end
                end
            end
            WAIT: begin
                ev_drop = is_head;
                // Finish lands cfg_interval cycles after start, never earlier than the next cycle
                if (wait_cnt_q <= 32'd1) begin
                    finish  = 1'b1;
                    state_d = IDLE;
                end
            end
            DISCARD: begin
                ev_drop = is_head;
                if (is_tail) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        ev_drop = ev_drop | store_err;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q              <= IDLE;
            wait_cnt_q           <= '0;
            out_wr_data          <= '0;
            out_wr_data_wr       <= 1'b0;
            out_wr_phv           <= '0;
            out_wr_phv_wr        <= 1'b0;
            out_wr_valid         <= 1'b0;
            out_wr_valid_wr      <= 1'b0;
            wr2ram_wr_en         <= 1'b0;
            wr2ram_addr          <= '0;
            wr2ram_wdata         <= '0;
            pgm_bypass_flag      <= 1'b0;
            pgm_sent_start_flag  <= 1'b0;
            pgm_sent_finish_flag <= 1'b0;
            pgm_pkt_len          <= '0;
            pgm_store_err        <= 1'b0;
        end else begin
            state_q              <= state_d;
            out_wr_data_wr       <= fwd;
            out_wr_phv_wr        <= fwd_head;
            out_wr_valid_wr      <= fwd_tail | trunc;
            wr2ram_wr_en         <= ram_wr;
            pgm_sent_start_flag  <= store_done;
            pgm_sent_finish_flag <= finish;
            pgm_store_err        <= store_err;
            if (fwd) out_wr_data <= in_wr_data;
            if (fwd_head) out_wr_phv <= in_wr_phv;
            if (fwd_tail || trunc) out_wr_valid <= fwd_tail & in_wr_valid;
            if (fwd_head) pgm_bypass_flag <= 1'b1;
            else if (fwd_tail || trunc) pgm_bypass_flag <= 1'b0;
            if (ram_wr) begin
                wr2ram_addr  <= wr_addr;
                wr2ram_wdata <= RAM_DW'(in_wr_data);
            end
            // wr2ram_addr still holds the previous word's address here, so +2 counts the tail too
            if (store_done) pgm_pkt_len <= {1'b0, wr2ram_addr} + LEN_OFS;
            if (store_done) wait_cnt_q <= cfg_interval;
            else if (state_q == WAIT && wait_cnt_q != 32'd0) wait_cnt_q <= wait_cnt_q - 32'd1;
        end
    end

    logic unused_inputs;
    assign unused_inputs = in_wr_phv_wr ^ in_wr_valid_wr;

`ifdef PGM_WRX_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_bypass_cnt <= '0;
            stat_store_cnt  <= '0;
            stat_drop_cnt   <= '0;
        end else begin
            if (fwd_tail) stat_bypass_cnt <= stat_bypass_cnt + 32'd1;
            if (store_done) stat_store_cnt <= stat_store_cnt + 32'd1;
            if (ev_drop) stat_drop_cnt <= stat_drop_cnt + 32'd1;
        end
    end
`else
    assign stat_bypass_cnt = '0;
    assign stat_store_cnt  = '0;
    assign stat_drop_cnt   = '0;

    logic unused_stats;
    assign unused_stats = ev_drop;
`endif

endmodule

// File: tb/tb_pgm_wrx.sv
// Directed bench for pgm_wrx (RAM_AW=3): bypass, store/wait, overflow, truncation,
// WAIT backpressure, mid-packet reset and zero interval.
module tb_pgm_wrx;

    localparam int unsigned DATA_W = 134;
    localparam int unsigned PHV_W  = 1024;
    localparam int unsigned RAM_AW = 3;
    localparam int unsigned RAM_DW = 144;
    localparam logic [1:0] HD = 2'b01;
    localparam logic [1:0] MD = 2'b11;
    localparam logic [1:0] TL = 2'b10;
`ifdef PGM_WRX_STATS_EN
    localparam int unsigned STATS = 1;
`else
    localparam int unsigned STATS = 0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic [DATA_W-1:0] in_wr_data;
    logic in_wr_data_wr, in_wr_phv_wr, in_wr_valid, in_wr_valid_wr;
    logic [PHV_W-1:0] in_wr_phv;
    logic [DATA_W-1:0] out_wr_data;
    logic out_wr_data_wr, out_wr_phv_wr, out_wr_valid, out_wr_valid_wr;
    logic [PHV_W-1:0] out_wr_phv;
    logic in_wr_alf, in_wr_phv_alf, out_wr_alf, out_wr_phv_alf;
    logic wr2ram_wr_en;
    logic [RAM_AW-1:0] wr2ram_addr;
    logic [RAM_DW-1:0] wr2ram_wdata;
    logic [31:0] cfg_interval;
    logic pgm_bypass_flag, pgm_sent_start_flag, pgm_sent_finish_flag, pgm_store_err;
    logic [RAM_AW:0] pgm_pkt_len;
    logic [31:0] stat_bypass_cnt, stat_store_cnt, stat_drop_cnt;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    pgm_wrx #(
        .DATA_W(DATA_W), .PHV_W(PHV_W), .RAM_AW(RAM_AW), .RAM_DW(RAM_DW), .STORE_TYPE(3'b111)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_wr_data(in_wr_data), .in_wr_data_wr(in_wr_data_wr),
        .in_wr_phv(in_wr_phv), .in_wr_phv_wr(in_wr_phv_wr),
        .in_wr_valid(in_wr_valid), .in_wr_valid_wr(in_wr_valid_wr),
        .out_wr_data(out_wr_data), .out_wr_data_wr(out_wr_data_wr),
        .out_wr_phv(out_wr_phv), .out_wr_phv_wr(out_wr_phv_wr),
        .out_wr_valid(out_wr_valid), .out_wr_valid_wr(out_wr_valid_wr),
        .in_wr_alf(in_wr_alf), .in_wr_phv_alf(in_wr_phv_alf),
        .out_wr_alf(out_wr_alf), .out_wr_phv_alf(out_wr_phv_alf),
        .wr2ram_wr_en(wr2ram_wr_en), .wr2ram_addr(wr2ram_addr), .wr2ram_wdata(wr2ram_wdata),
        .cfg_interval(cfg_interval), .pgm_bypass_flag(pgm_bypass_flag),
        .pgm_sent_start_flag(pgm_sent_start_flag), .pgm_sent_finish_flag(pgm_sent_finish_flag),
        .pgm_pkt_len(pgm_pkt_len), .pgm_store_err(pgm_store_err),
        .stat_bypass_cnt(stat_bypass_cnt), .stat_store_cnt(stat_store_cnt),
        .stat_drop_cnt(stat_drop_cnt)
    );

    function automatic logic [DATA_W-1:0] mkw(input logic [1:0] tg, input logic [2:0] ty,
                                              input logic [31:0] pl);
        logic [DATA_W-1:0] w;
        w = '0;
        w[DATA_W-1 -: 2] = tg;
        w[111:109] = ty;
        w[31:0] = pl;
        return w;
    endfunction

    task automatic chk(input string name, input logic [143:0] got, input logic [143:0] exp);
        checks++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", name, got, exp);
        end
    endtask

    // Present one input word, clock it in, and return 1 time unit after the edge
    task automatic cycle(input logic [DATA_W-1:0] w, input logic wr);
        in_wr_data = w;
        in_wr_data_wr = wr;
        @(posedge clk);
        #1;
    endtask

    logic [DATA_W-1:0] w;
    logic [PHV_W-1:0] exp_phv;
    int nwr, nerr, found, at;

    initial begin
        rst_n = 1'b1;
        in_wr_data = '0; in_wr_data_wr = 1'b0; in_wr_phv = '0; in_wr_phv_wr = 1'b0;
        in_wr_valid = 1'b0; in_wr_valid_wr = 1'b0; in_wr_alf = 1'b0; in_wr_phv_alf = 1'b0;
        cfg_interval = 32'd10;
        exp_phv = {32{32'hDEADBEEF}};
        #2 rst_n = 1'b0;
        #1;
        chk("rst_data_wr", out_wr_data_wr, 0);
        chk("rst_ram_wr", wr2ram_wr_en, 0);
        chk("rst_bypass_flag", pgm_bypass_flag, 0);
        chk("rst_pkt_len", pgm_pkt_len, 0);
        chk("rst_alf", out_wr_alf, 0);
        chk("rst_stat_drop", stat_drop_cnt, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Bypass: head, ignored strobe-less cycle, middle, tail
        in_wr_phv = exp_phv; in_wr_valid = 1'b1; in_wr_valid_wr = 1'b1; in_wr_phv_wr = 1'b1;
        w = mkw(HD, 3'b001, 32'hA1);
        cycle(w, 1'b1);
        chk("byp_h_data_wr", out_wr_data_wr, 1);
        chk("byp_h_data", out_wr_data, w);
        chk("byp_h_phv_wr", out_wr_phv_wr, 1);
        checks++;
        assert (out_wr_phv === exp_phv) else begin
            fails++;
            $error("FAIL byp_h_phv: observed %0h expected %0h", out_wr_phv[31:0], exp_phv[31:0]);
        end
        chk("byp_flag_set", pgm_bypass_flag, 1);
        chk("byp_h_valid_wr", out_wr_valid_wr, 0);
        cycle(mkw(HD, 3'b111, 32'hBAD), 1'b0);
        chk("byp_nostrobe", out_wr_data_wr, 0);
        w = mkw(MD, 3'b000, 32'hA2);
        cycle(w, 1'b1);
        chk("byp_m_data", out_wr_data, w);
        chk("byp_m_phv_wr", out_wr_phv_wr, 0);
        w = mkw(TL, 3'b000, 32'hA3);
        cycle(w, 1'b1);
        chk("byp_t_data_wr", out_wr_data_wr, 1);
        chk("byp_t_data", out_wr_data, w);
        chk("byp_t_valid_wr", out_wr_valid_wr, 1);
        chk("byp_t_valid", out_wr_valid, 1);
        chk("byp_flag_clr", pgm_bypass_flag, 0);
        cycle('0, 1'b0);
        chk("byp_idle_data_wr", out_wr_data_wr, 0);
        chk("byp_idle_valid_wr", out_wr_valid_wr, 0);

        // Store: 5 words at addresses 0..4, then a 10-cycle wait
        for (int i = 0; i < 5; i++) begin
            w = mkw((i == 0) ? HD : ((i == 4) ? TL : MD), 3'b111, 32'hB0 + i);
            cycle(w, 1'b1);
            chk("st_wr_en", wr2ram_wr_en, 1);
            chk("st_addr", wr2ram_addr, i);
            chk("st_wdata", wr2ram_wdata, {10'b0, w});
            chk("st_no_fwd", out_wr_data_wr, 0);
        end
        chk("st_start", pgm_sent_start_flag, 1);
        chk("st_pkt_len", pgm_pkt_len, 5);
        chk("st_alf_wait", out_wr_alf, 1);
        chk("st_phv_alf_wait", out_wr_phv_alf, 1);
        found = 0; at = 0;
        for (int k = 1; k <= 20; k++) begin
            cycle('0, 1'b0);
            if (k == 1) chk("st_start_pulse", pgm_sent_start_flag, 0);
            if (pgm_sent_finish_flag && found == 0) begin
                found = 1;
                at = k;
                chk("st_alf_after", out_wr_alf, 0);
            end
        end
        chk("st_finish_seen", found, 1);
        chk("st_finish_delay", at, 10);

        // Overflow: 10-word store packet into an 8-word RAM
        nwr = 0; nerr = 0;
        for (int i = 0; i < 10; i++) begin
            cycle(mkw((i == 0) ? HD : ((i == 9) ? TL : MD), 3'b111, 32'hC0 + i), 1'b1);
            nwr += int'(wr2ram_wr_en);
            nerr += int'(pgm_store_err);
            if (i == 8) chk("ovf_err_word9", pgm_store_err, 1);
        end
        chk("ovf_writes", nwr, 8);
        chk("ovf_err_count", nerr, 1);
        chk("ovf_no_start", pgm_sent_start_flag, 0);

        // Missing tail: second head in BYPASS truncates and the new packet is discarded
        cycle(mkw(HD, 3'b001, 32'hD1), 1'b1);
        chk("trc_h_data_wr", out_wr_data_wr, 1);
        cycle(mkw(MD, 3'b000, 32'hD2), 1'b1);
        cycle(mkw(HD, 3'b001, 32'hD3), 1'b1);
        chk("trc_valid_wr", out_wr_valid_wr, 1);
        chk("trc_valid", out_wr_valid, 0);
        chk("trc_h2_data_wr", out_wr_data_wr, 0);
        chk("trc_flag", pgm_bypass_flag, 0);
        cycle(mkw(MD, 3'b000, 32'hD4), 1'b1);
        chk("trc_m2_drop", out_wr_data_wr, 0);
        cycle(mkw(TL, 3'b000, 32'hD5), 1'b1);
        chk("trc_t2_drop", out_wr_data_wr, 0);
        chk("trc_t2_valid_wr", out_wr_valid_wr, 0);
        cycle('0, 1'b0);
        chk("stat_bypass_1", stat_bypass_cnt, 1 * STATS);
        chk("stat_store_1", stat_store_cnt, 1 * STATS);
        chk("stat_drop_2", stat_drop_cnt, 2 * STATS);

        // Reset in the middle of STORE, then orphan words and a clean bypass packet
        cycle(mkw(HD, 3'b111, 32'hE1), 1'b1);
        cycle(mkw(MD, 3'b000, 32'hE2), 1'b1);
        chk("mid_wr_en", wr2ram_wr_en, 1);
        chk("mid_addr", wr2ram_addr, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_wr_en", wr2ram_wr_en, 0);
        chk("arst_addr", wr2ram_addr, 0);
        chk("arst_wdata", wr2ram_wdata, 0);
        chk("arst_stat_drop", stat_drop_cnt, 0);
        in_wr_data_wr = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        cycle(mkw(MD, 3'b000, 32'hE3), 1'b1);
        chk("orph_m_ram", wr2ram_wr_en, 0);
        chk("orph_m_fwd", out_wr_data_wr, 0);
        cycle(mkw(TL, 3'b000, 32'hE4), 1'b1);
        chk("orph_t_fwd", out_wr_data_wr, 0);
        w = mkw(HD, 3'b010, 32'hF1);
        cycle(w, 1'b1);
        chk("post_h_data", out_wr_data, w);
        chk("post_h_phv_wr", out_wr_phv_wr, 1);
        cycle(mkw(TL, 3'b000, 32'hF2), 1'b1);
        chk("post_t_valid_wr", out_wr_valid_wr, 1);
        chk("post_t_data_wr", out_wr_data_wr, 1);

        // WAIT backpressure: a packet arriving during WAIT is dropped
        cfg_interval = 32'd20;
        cycle(mkw(HD, 3'b111, 32'h11), 1'b1);
        cycle(mkw(TL, 3'b000, 32'h12), 1'b1);
        chk("wt_pkt_len", pgm_pkt_len, 2);
        for (int i = 0; i < 3; i++) begin
            cycle(mkw((i == 0) ? HD : ((i == 2) ? TL : MD), 3'b001, 32'h20 + i), 1'b1);
            chk("wt_alf", out_wr_alf, 1);
            chk("wt_drop", out_wr_data_wr, 0);
        end
        found = 0;
        for (int k = 0; k < 30 && found == 0; k++) begin
            cycle('0, 1'b0);
            if (pgm_sent_finish_flag) found = 1;
        end
        chk("wt_finish_seen", found, 1);
        chk("wt_stat_drop", stat_drop_cnt, 1 * STATS);

        // Zero interval: finish on the cycle right after start
        cfg_interval = 32'd0;
        cycle(mkw(HD, 3'b111, 32'h31), 1'b1);
        cycle(mkw(TL, 3'b000, 32'h32), 1'b1);
        chk("z_start", pgm_sent_start_flag, 1);
        cycle('0, 1'b0);
        chk("z_finish", pgm_sent_finish_flag, 1);
        chk("z_start_clr", pgm_sent_start_flag, 0);
        cycle('0, 1'b0);
        chk("z_finish_clr", pgm_sent_finish_flag, 0);
        chk("end_stat_bypass", stat_bypass_cnt, 1 * STATS);
        chk("end_stat_store", stat_store_cnt, 2 * STATS);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/pgm_wrx.md
PGM_WRX -- requirements
Module: pgm_wrx

Interface
REQ-001 SHALL have parameter DATA_W, default 134, meaning data bus width; bits [DATA_W-1:DATA_W-2] carry the word tag (01 head, 11 middle, 10 tail).
REQ-002 SHALL have parameter PHV_W, default 1024, meaning PHV width.
REQ-003 SHALL have parameter RAM_AW, default 7, meaning store RAM address width (depth 2^RAM_AW words).
REQ-004 SHALL have parameter RAM_DW, default 144, meaning RAM word width (RAM_DW >= DATA_W; data is zero-extended in the MSBs).
REQ-005 SHALL have parameter STORE_TYPE, default 3'b111, meaning the head-word type value in bits [111:109] that selects store mode.
REQ-006 SHALL have ports: clk in 1 clock; rst_n in 1 reset, asynchronous, active-low.
REQ-007 SHALL have ports: in_wr_data in DATA_W; in_wr_data_wr in 1 (word strobe); in_wr_phv in PHV_W; in_wr_phv_wr in 1; in_wr_valid in 1; in_wr_valid_wr in 1.
REQ-008 SHALL have ports: out_wr_data out DATA_W; out_wr_data_wr out 1; out_wr_phv out PHV_W; out_wr_phv_wr out 1; out_wr_valid out 1; out_wr_valid_wr out 1.
REQ-009 SHALL have ports: in_wr_alf in 1; in_wr_phv_alf in 1; out_wr_alf out 1; out_wr_phv_alf out 1 (upstream backpressure).
REQ-010 SHALL have ports: wr2ram_wr_en out 1; wr2ram_addr out RAM_AW; wr2ram_wdata out RAM_DW.
REQ-011 SHALL have ports: cfg_interval in 32 (wait cycles after store); pgm_bypass_flag out 1; pgm_sent_start_flag out 1; pgm_sent_finish_flag out 1; pgm_pkt_len out RAM_AW+1 (stored word count); pgm_store_err out 1.
REQ-012 SHALL have ports: stat_bypass_cnt, stat_store_cnt, stat_drop_cnt, out 32 each.

Function
REQ-013 SHALL accept a word only in cycles with in_wr_data_wr=1; all other cycles are ignored for data.
REQ-014 SHALL implement states IDLE, BYPASS, STORE, WAIT, DISCARD.
REQ-015 IDLE, head with type != STORE_TYPE: forward word and PHV, pgm_bypass_flag=1, go BYPASS.
REQ-016 IDLE, head with type == STORE_TYPE: write word at address 0, go STORE.
REQ-017 IDLE, non-head word: drop silently, remain in IDLE.
REQ-018 Bypass path SHALL register outputs with 1-cycle latency; out_wr_data_wr mirrors the accepted strobe; out_wr_phv_wr pulses only with the head.
REQ-019 BYPASS tail: forward the word, pulse out_wr_valid_wr=1 with out_wr_valid=in_wr_valid, clear pgm_bypass_flag, go IDLE.
REQ-020 STORE middle/tail: write at address+1, one RAM write per accepted word.
REQ-021 STORE tail: pgm_pkt_len=number of words written (1..2^RAM_AW), pgm_sent_start_flag one-cycle pulse, load wait counter, go WAIT.
REQ-022 STORE, non-tail word arriving with address=2^RAM_AW-1: no write, pgm_store_err one-cycle pulse, go DISCARD.
REQ-023 WAIT SHALL count cfg_interval cycles, then pulse pgm_sent_finish_flag for one cycle and go IDLE; cfg_interval=0 gives finish on the cycle after start.
REQ-024 out_wr_alf = in_wr_alf OR state==WAIT; out_wr_phv_alf = in_wr_phv_alf OR state==WAIT.
REQ-025 Words accepted in WAIT SHALL be dropped; each head dropped counts once in stat_drop_cnt.
REQ-026 Head arriving in BYPASS: emit out_wr_valid_wr=1 with out_wr_valid=0 (truncated), go DISCARD; in STORE: pgm_store_err pulse, go DISCARD.
REQ-027 DISCARD SHALL drop words until a tail is accepted, then go IDLE.
REQ-028 Counters SHALL increment on bypass tail, store tail, and drop/error events respectively, and SHALL wrap at 2^32.

Reset
REQ-029 On rst_n=0, all outputs SHALL be 0, state SHALL be IDLE, and counters SHALL be 0, asynchronously.
REQ-030 Reset mid-packet SHALL abandon the packet; after release, words before the next head SHALL be dropped.

Configuration
REQ-031 With PGM_WRX_STATS_EN defined, the stat_* counters SHALL be implemented; without it, the stat_* outputs SHALL be tied to 0 and no counter logic SHALL be present.

Verification
REQ-032 Bypass: 3-word packet with type 3'b001 -> 3 out_wr_data_wr pulses at 1-cycle latency, out_wr_phv_wr with the head, out_wr_valid_wr with the tail.
REQ-033 Store: 5-word packet with type 3'b111, cfg_interval=10 -> RAM writes at addresses 0-4, pgm_pkt_len=5, start pulse, finish pulse 10 cycles later.
REQ-034 Overflow with RAM_AW=3: 10-word store packet -> 8 writes, pgm_store_err pulse, remaining words dropped, IDLE after the tail.
REQ-035 Missing tail: head, middle, then a new head in BYPASS -> truncated marker (valid_wr=1, valid=0), second packet dropped.
REQ-036 WAIT backpressure: packet sent during WAIT -> out_wr_alf=1, packet dropped, stat_drop_cnt=1 (macro on), 0 (macro off).
REQ-037 Reset asserted in the middle of STORE -> all outputs 0 immediately; a following bypass packet passes normally.
